// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between I-cache refills
// and D-cache refills/writebacks; sequences command, write and read phases.
module mem_arbiter #(
  parameter int BEATS  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  output logic              i_resp_last,
  output logic [DATA_W-1:0] i_resp_data,

  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_rnw,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_wdata_ready,
  output logic              d_resp_valid,
  output logic              d_resp_last,
  output logic [DATA_W-1:0] d_resp_data,

  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_rnw,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(BEATS * DATA_W / 8);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  LAST_CNT   = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CMD   = 2'd1,
    WDATA = 2'd2,
    RDATA = 2'd3
  } state_t;

  // owner / last_grant encoding: 0 = I side, 1 = D side
  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              rnw_q, rnw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              wvalid_q, wvalid_d;

  logic idle_ok;
  logic grant_d_side;
  logic last_beat;
  logic w_hs;
  logic r_beat;

  // No acceptance while reset is held, so nothing is acknowledged that is then lost.
  assign idle_ok      = (state_q == IDLE) && !rst;
  assign grant_d_side = d_req_valid && (!i_req_valid || !last_grant_q);
  assign i_req_ready  = idle_ok && i_req_valid && !grant_d_side;
  assign d_req_ready  = idle_ok && grant_d_side;

  assign last_beat = (cnt_q == LAST_CNT);
  assign w_hs      = wvalid_q && mem_wdata_ready;
  assign r_beat    = (state_q == RDATA) && mem_rdata_valid;

  assign mem_cmd_valid   = cmd_valid_q;
  assign mem_cmd_rnw     = rnw_q;
  assign mem_cmd_addr    = addr_q;
  assign mem_wdata_valid = wvalid_q;
  assign mem_wdata       = wvalid_q ? d_wdata : '0;
  assign d_wdata_ready   = w_hs;

  // Read beats pass straight through; there is no response backpressure.
  assign i_resp_valid = r_beat && !owner_q;
  assign d_resp_valid = r_beat && owner_q;
  assign i_resp_last  = i_resp_valid && last_beat;
  assign d_resp_last  = d_resp_valid && last_beat;
  assign i_resp_data  = mem_rdata;
  assign d_resp_data  = mem_rdata;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    rnw_d        = rnw_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    cmd_valid_d  = cmd_valid_q;
    wvalid_d     = wvalid_q;

    case (state_q)
      IDLE: begin
        if (i_req_ready || d_req_ready) begin
          owner_d      = d_req_ready;
          last_grant_d = d_req_ready;
          rnw_d        = d_req_ready ? d_req_rnw : 1'b1;
          addr_d       = (d_req_ready ? d_req_addr : i_req_addr) & ALIGN_MASK;
          cmd_valid_d  = 1'b1;
          state_d      = CMD;
        end
      end
      CMD: begin
        if (mem_cmd_ready) begin
          cmd_valid_d = 1'b0;
          cnt_d       = '0;
          if (rnw_q) begin
            state_d = RDATA;
          end else begin
            state_d  = WDATA;
            wvalid_d = 1'b1;
          end
        end
      end
      WDATA: begin
        if (w_hs) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            wvalid_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      RDATA: begin
        if (r_beat) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (last_beat) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      rnw_q        <= 1'b0;
      addr_q       <= '0;
      cnt_q        <= '0;
      cmd_valid_q  <= 1'b0;
      wvalid_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      rnw_q        <= rnw_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      cmd_valid_q  <= cmd_valid_d;
      wvalid_q     <= wvalid_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reads, fairness, writeback, command stall,
// spurious beats and asynchronous reset mid-burst.
module tb_mem_arbiter;

  localparam int BEATS  = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req_valid;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr;
  logic              i_resp_valid;
  logic              i_resp_last;
  logic [DATA_W-1:0] i_resp_data;
  logic              d_req_valid;
  logic              d_req_ready;
  logic              d_req_rnw;
  logic [ADDR_W-1:0] d_req_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_wdata_ready;
  logic              d_resp_valid;
  logic              d_resp_last;
  logic [DATA_W-1:0] d_resp_data;
  logic              mem_cmd_valid;
  logic              mem_cmd_ready;
  logic              mem_cmd_rnw;
  logic [ADDR_W-1:0] mem_cmd_addr;
  logic              mem_wdata_valid;
  logic              mem_wdata_ready;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rdata_valid;
  logic [DATA_W-1:0] mem_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  mem_arbiter #(.BEATS(BEATS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_req_valid     (i_req_valid),
    .i_req_ready     (i_req_ready),
    .i_req_addr      (i_req_addr),
    .i_resp_valid    (i_resp_valid),
    .i_resp_last     (i_resp_last),
    .i_resp_data     (i_resp_data),
    .d_req_valid     (d_req_valid),
    .d_req_ready     (d_req_ready),
    .d_req_rnw       (d_req_rnw),
    .d_req_addr      (d_req_addr),
    .d_wdata         (d_wdata),
    .d_wdata_ready   (d_wdata_ready),
    .d_resp_valid    (d_resp_valid),
    .d_resp_last     (d_resp_last),
    .d_resp_data     (d_resp_data),
    .mem_cmd_valid   (mem_cmd_valid),
    .mem_cmd_ready   (mem_cmd_ready),
    .mem_cmd_rnw     (mem_cmd_rnw),
    .mem_cmd_addr    (mem_cmd_addr),
    .mem_wdata_valid (mem_wdata_valid),
    .mem_wdata_ready (mem_wdata_ready),
    .mem_wdata       (mem_wdata),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input logic exp_i, input logic exp_d);
    @(negedge clk);
    chk("i_req_ready", i_req_ready, exp_i);
    chk("d_req_ready", d_req_ready, exp_d);
    tick();
  endtask

  task automatic cmd_stage(input logic [31:0] exp_addr, input logic exp_rnw);
    mem_cmd_ready = 1'b1;
    @(negedge clk);
    chk("cmd_valid", mem_cmd_valid, 1);
    chk("cmd_addr", mem_cmd_addr, exp_addr);
    chk("cmd_rnw", mem_cmd_rnw, exp_rnw);
    chk("cmd_i_ready", i_req_ready, 0);
    chk("cmd_d_ready", d_req_ready, 0);
    tick();
    mem_cmd_ready = 1'b0;
  endtask

  task automatic read_burst(input logic to_d, input logic [31:0] base, input int nbeats);
    for (int k = 0; k < nbeats; k++) begin
      mem_rdata_valid = 1'b1;
      mem_rdata       = base + 32'(k);
      @(negedge clk);
      chk("own_resp_valid", to_d ? d_resp_valid : i_resp_valid, 1);
      chk("oth_resp_valid", to_d ? i_resp_valid : d_resp_valid, 0);
      chk("resp_data", to_d ? d_resp_data : i_resp_data, base + 32'(k));
      chk("resp_last", to_d ? d_resp_last : i_resp_last, (k == BEATS - 1));
      tick();
    end
    mem_rdata_valid = 1'b0;
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_i_ready"}, i_req_ready, 0);
    chk({tag, "_d_ready"}, d_req_ready, 0);
    chk({tag, "_i_resp"}, {i_resp_valid, i_resp_last}, 0);
    chk({tag, "_d_resp"}, {d_resp_valid, d_resp_last}, 0);
    chk({tag, "_cmd_valid"}, mem_cmd_valid, 0);
    chk({tag, "_cmd_addr"}, mem_cmd_addr, 0);
    chk({tag, "_cmd_rnw"}, mem_cmd_rnw, 0);
    chk({tag, "_wvalid"}, mem_wdata_valid, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_wready"}, d_wdata_ready, 0);
  endtask

  initial begin
    int k;
    int c;
    logic mw;

    rst             = 1'b1;
    i_req_valid     = 1'b0;
    i_req_addr      = '0;
    d_req_valid     = 1'b0;
    d_req_rnw       = 1'b0;
    d_req_addr      = '0;
    d_wdata         = 32'hDEAD_BEEF;
    mem_cmd_ready   = 1'b0;
    mem_wdata_ready = 1'b1;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;

    #12;
    reset_outputs("rst");
    tick();
    mem_wdata_ready = 1'b0;
    rst = 1'b0;

    // I read of 0x1234 -> aligned command, four beats to I only
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_1234;
    expect_grant(1, 0);
    i_req_valid = 1'b0;
    i_req_addr  = 32'hFFFF_FFFF;
    cmd_stage(32'h0000_1230, 1);
    read_burst(0, 32'hA0, 4);
    @(negedge clk);
    chk("post_rd_cmd_valid", mem_cmd_valid, 0);
    chk("post_rd_i_ready", i_req_ready, 0);
    tick();

    // fairness from reset: D, I, D
    rst = 1'b1;
    tick();
    rst = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_0100;
    d_req_valid = 1'b1;
    d_req_rnw   = 1'b1;
    d_req_addr  = 32'h0000_0200;
    expect_grant(0, 1);
    cmd_stage(32'h0000_0200, 1);
    read_burst(1, 32'hB0, 4);
    expect_grant(1, 0);
    cmd_stage(32'h0000_0100, 1);
    read_burst(0, 32'hC0, 4);
    expect_grant(0, 1);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    cmd_stage(32'h0000_0200, 1);
    read_burst(1, 32'hD0, 4);

    // spurious read beats while idle
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'hEE;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      chk("idle_spur_i", i_resp_valid, 0);
      chk("idle_spur_d", d_resp_valid, 0);
      tick();
    end
    mem_rdata_valid = 1'b0;

    // D writeback to 0x44 with memory ready toggling, spurious read beats throughout
    d_req_valid = 1'b1;
    d_req_rnw   = 1'b0;
    d_req_addr  = 32'h0000_0044;
    expect_grant(0, 1);
    d_req_valid = 1'b0;
    d_req_rnw   = 1'b1;
    cmd_stage(32'h0000_0040, 0);
    mem_rdata_valid = 1'b1;
    k = 0;
    c = 0;
    while (k < BEATS && c < 20) begin
      mw              = (c % 2 == 0);
      mem_wdata_ready = mw;
      d_wdata         = 32'hD0 + 32'(k);
      @(negedge clk);
      chk("wr_valid", mem_wdata_valid, 1);
      chk("wr_data", mem_wdata, 32'hD0 + 32'(k));
      chk("wr_ready_mirror", d_wdata_ready, mw);
      chk("wr_spur_resp", {i_resp_valid, d_resp_valid}, 0);
      tick();
      if (mw) k++;
      c++;
    end
    chk("wr_beats", k, BEATS);
    chk("wr_cycles", c, 7);
    mem_wdata_ready = 1'b1;
    @(negedge clk);
    chk("wr_done_valid", mem_wdata_valid, 0);
    chk("wr_done_ready", d_wdata_ready, 0);
    chk("wr_done_data", mem_wdata, 0);
    chk("wr_done_resp", {i_resp_valid, d_resp_valid}, 0);
    tick();
    mem_wdata_ready = 1'b0;
    mem_rdata_valid = 1'b0;

    // command stall: last grant was D, so I wins the tie
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_2008;
    d_req_valid = 1'b1;
    d_req_rnw   = 1'b1;
    d_req_addr  = 32'h0000_0300;
    expect_grant(1, 0);
    i_req_addr      = 32'h0000_5550;
    mem_rdata_valid = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("stall_cmd_valid", mem_cmd_valid, 1);
      chk("stall_cmd_addr", mem_cmd_addr, 32'h0000_2000);
      chk("stall_cmd_rnw", mem_cmd_rnw, 1);
      chk("stall_readies", {i_req_ready, d_req_ready}, 0);
      chk("stall_resp", {i_resp_valid, d_resp_valid}, 0);
      tick();
    end
    mem_rdata_valid = 1'b0;
    i_req_valid     = 1'b0;
    d_req_valid     = 1'b0;
    cmd_stage(32'h0000_2000, 1);
    read_burst(0, 32'hE0, 4);

    // async reset during beat 2 of an I read
    i_req_valid = 1'b1;
    i_req_addr  = 32'h0000_3000;
    expect_grant(1, 0);
    i_req_valid = 1'b0;
    cmd_stage(32'h0000_3000, 1);
    read_burst(0, 32'hF0, 2);
    mem_rdata_valid = 1'b1;
    mem_rdata       = 32'hF2;
    @(negedge clk);
    chk("beat2_valid", i_resp_valid, 1);
    #1 rst = 1'b1;
    #1;
    reset_outputs("mid_rst");
    tick();
    rst             = 1'b0;
    mem_rdata_valid = 1'b0;
    i_req_valid     = 1'b1;
    i_req_addr      = 32'h0000_3010;
    expect_grant(1, 0);
    i_req_valid = 1'b0;
    cmd_stage(32'h0000_3010, 1);
    read_burst(0, 32'h90, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
